// File: rtl/regpair_sequencer.sv
// Register-pair sequencer: drives an 8-bit register bank to perform MOV8, LD16, INC16 and DEC16.
// Optional macro REGSEQ_ZERO_FLAG_EN adds a registered zeroFlag output for 16-bit arithmetic results.
module regpair_sequencer #(
  parameter logic [2:0] IDLE_REG = 3'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [1:0]  cmdOp,
  input  logic [2:0]  cmdDst,
  input  logic [2:0]  cmdSrc,
  input  logic [15:0] cmdImm,
  output logic [2:0]  bankRegNum,
  output logic        bankWriteEnable,
  output logic [7:0]  bankDataIn,
  input  logic [7:0]  bankDataOut,
  input  logic [15:0] bankDataOut16,
  output logic        done,
  output logic        busy
`ifdef REGSEQ_ZERO_FLAG_EN
  ,
  output logic        zeroFlag
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WRLO = 3'd2,
    S_WRHI = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_MOV8  = 2'b00;
  localparam logic [1:0] OP_LD16  = 2'b01;
  localparam logic [1:0] OP_DEC16 = 2'b11;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [2:0]  r_dst;
  logic [15:0] r_cap;
  logic [15:0] w_arith;

  // Pair arithmetic wraps modulo 2^16; no carry leaves the block.
  always_comb begin
    w_arith = bankDataOut16 + 16'd1;
    if (r_op == OP_DEC16) begin
      w_arith = bankDataOut16 - 16'd1;
    end else begin
      w_arith = bankDataOut16 + 16'd1;
    end
  end

  // Sequencer FSM; every output is registered and loaded for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_op            <= 2'b00;
      r_dst           <= 3'd0;
      r_cap           <= 16'h0000;
      cmdReady        <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      bankWriteEnable <= 1'b0;
      bankRegNum      <= IDLE_REG;
      bankDataIn      <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmdValid) begin
            r_op     <= cmdOp;
            r_dst    <= cmdDst;
            cmdReady <= 1'b0;
            busy     <= 1'b1;
            if (cmdOp == OP_LD16) begin
              r_state         <= S_WRLO;
              r_cap           <= cmdImm;
              bankRegNum      <= {cmdDst[2:1], 1'b1};
              bankWriteEnable <= 1'b1;
              bankDataIn      <= cmdImm[7:0];
            end else begin
              r_state    <= S_READ;
              bankRegNum <= (cmdOp == OP_MOV8) ? cmdSrc : {cmdDst[2:1], 1'b0};
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          bankWriteEnable <= 1'b1;
          if (r_op == OP_MOV8) begin
            r_state    <= S_WRHI;
            r_cap      <= {8'h00, bankDataOut};
            bankRegNum <= r_dst;
            bankDataIn <= bankDataOut;
          end else begin
            r_state    <= S_WRLO;
            r_cap      <= w_arith;
            bankRegNum <= {r_dst[2:1], 1'b1};
            bankDataIn <= w_arith[7:0];
          end
        end
        S_WRLO: begin
          r_state         <= S_WRHI;
          bankRegNum      <= {r_dst[2:1], 1'b0};
          bankWriteEnable <= 1'b1;
          bankDataIn      <= r_cap[15:8];
        end
        S_WRHI: begin
          r_state         <= S_DONE;
          bankRegNum      <= IDLE_REG;
          bankWriteEnable <= 1'b0;
          bankDataIn      <= 8'h00;
          done            <= 1'b1;
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          cmdReady <= 1'b1;
        end
        default: begin
          r_state         <= S_IDLE;
          cmdReady        <= 1'b1;
          busy            <= 1'b0;
          done            <= 1'b0;
          bankWriteEnable <= 1'b0;
          bankRegNum      <= IDLE_REG;
          bankDataIn      <= 8'h00;
        end
      endcase
    end
  end

`ifdef REGSEQ_ZERO_FLAG_EN
  // Sampled on entry to DONE; only INC16/DEC16 (op bit 1 set) update it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zeroFlag <= 1'b0;
    end else if ((r_state == S_WRHI) && r_op[1]) begin
      zeroFlag <= (r_cap == 16'h0000);
    end else begin
      zeroFlag <= zeroFlag;
    end
  end
`endif

endmodule

// File: tb/tb_regpair_sequencer.sv
// Directed self-checking bench for regpair_sequencer with a behavioural 8x8 register bank.
module tb_regpair_sequencer;

  localparam logic [2:0] P_IDLE = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [2:0]  cmdDst;
  logic [2:0]  cmdSrc;
  logic [15:0] cmdImm;
  logic [2:0]  bankRegNum;
  logic        bankWriteEnable;
  logic [7:0]  bankDataIn;
  logic [7:0]  bankDataOut;
  logic [15:0] bankDataOut16;
  logic        done;
  logic        busy;
`ifdef REGSEQ_ZERO_FLAG_EN
  logic        zeroFlag;
`endif

  logic [7:0] regs [8];
  int wcnt = 0;
  int dcnt = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regpair_sequencer #(.IDLE_REG(P_IDLE)) dut (
    .clk(clk), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdDst(cmdDst), .cmdSrc(cmdSrc), .cmdImm(cmdImm),
    .bankRegNum(bankRegNum), .bankWriteEnable(bankWriteEnable), .bankDataIn(bankDataIn),
    .bankDataOut(bankDataOut), .bankDataOut16(bankDataOut16),
    .done(done), .busy(busy)
`ifdef REGSEQ_ZERO_FLAG_EN
    , .zeroFlag(zeroFlag)
`endif
  );

  assign bankDataOut   = regs[bankRegNum];
  assign bankDataOut16 = {regs[bankRegNum], regs[bankRegNum | 3'd1]};

  always @(posedge clk) begin
    if (bankWriteEnable) begin
      regs[bankRegNum] <= bankDataIn;
      wcnt <= wcnt + 1;
    end
    if (done) dcnt <= dcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ready"}, 16'(cmdReady), 16'd1);
    check({tag, ".busy"}, 16'(busy), 16'd0);
    check({tag, ".done"}, 16'(done), 16'd0);
    check({tag, ".we"}, 16'(bankWriteEnable), 16'd0);
    check({tag, ".regnum"}, 16'(bankRegNum), 16'(P_IDLE));
    check({tag, ".datain"}, 16'(bankDataIn), 16'h0000);
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] dst,
                         input logic [2:0] src, input logic [15:0] imm,
                         input int exp_lat, input int exp_writes);
    int lat;
    int w0;
    cmdValid = 1'b1; cmdOp = op; cmdDst = dst; cmdSrc = src; cmdImm = imm;
    step();
    cmdValid = 1'b0;
    w0 = wcnt;
    lat = 1;
    while (!done && lat < 12) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, 16'(lat), 16'(exp_lat));
    check({tag, ".writes"}, 16'(wcnt - w0), 16'(exp_writes));
    check({tag, ".done_regnum"}, 16'(bankRegNum), 16'(P_IDLE));
    step();
    check({tag, ".done_pulse"}, 16'(done), 16'd0);
    check({tag, ".ready_after"}, 16'(cmdReady), 16'd1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; cmdValid = 1'b0; cmdOp = 2'b00; cmdDst = 3'd0; cmdSrc = 3'd0; cmdImm = 16'h0000;
    #3;
    check_idle_outputs("reset0");
    @(negedge clk); reset = 1'b0;
    step();
    check_idle_outputs("idle");

    // LD16 p=1 imm BEEF, cmdDst[0]=1 must be ignored
    cmdValid = 1'b1; cmdOp = 2'b01; cmdDst = 3'd3; cmdImm = 16'hBEEF;
    step();
    cmdValid = 1'b0;
    check("ld.wrlo_we", 16'(bankWriteEnable), 16'd1);
    check("ld.wrlo_reg", 16'(bankRegNum), 16'd3);
    check("ld.wrlo_data", 16'(bankDataIn), 16'h00EF);
    check("ld.busy", 16'(busy), 16'd1);
    check("ld.ready", 16'(cmdReady), 16'd0);
    step();
    check("ld.wrhi_reg", 16'(bankRegNum), 16'd2);
    check("ld.wrhi_data", 16'(bankDataIn), 16'h00BE);
    check("ld.reg3", 16'(regs[3]), 16'h00EF);
    step();
    check("ld.done", 16'(done), 16'd1);
    check("ld.done_we", 16'(bankWriteEnable), 16'd0);
    check("ld.done_data", 16'(bankDataIn), 16'h0000);
    check("ld.reg2", 16'(regs[2]), 16'h00BE);
    step();
    check_idle_outputs("ld.after");

    // HL=FFFF then INC16 p=2 wraps to 0000
    run_cmd("pre_hl", 2'b01, 3'd4, 3'd0, 16'hFFFF, 3, 2);
    run_cmd("inc", 2'b10, 3'd4, 3'd0, 16'h0000, 4, 2);
    check("inc.reg4", 16'(regs[4]), 16'h0000);
    check("inc.reg5", 16'(regs[5]), 16'h0000);
`ifdef REGSEQ_ZERO_FLAG_EN
    check("inc.zf", 16'(zeroFlag), 16'd1);
`endif

    // B=5A via LD16 p=0, then MOV8 B->Z
    run_cmd("pre_b", 2'b01, 3'd0, 3'd0, 16'h5A00, 3, 2);
    run_cmd("mov", 2'b00, 3'd7, 3'd0, 16'h0000, 3, 1);
    check("mov.reg7", 16'(regs[7]), 16'h005A);
`ifdef REGSEQ_ZERO_FLAG_EN
    check("mov.zf_held", 16'(zeroFlag), 16'd1);
`endif

    // BC=0100, DEC16 p=0 via cmdDst=1
    run_cmd("pre_bc", 2'b01, 3'd0, 3'd0, 16'h0100, 3, 2);
    run_cmd("dec", 2'b11, 3'd1, 3'd0, 16'h0000, 4, 2);
    check("dec.reg0", 16'(regs[0]), 16'h0000);
    check("dec.reg1", 16'(regs[1]), 16'h00FF);
`ifdef REGSEQ_ZERO_FLAG_EN
    check("dec.zf", 16'(zeroFlag), 16'd0);
`endif

    // WZ=0000, DEC16 wraps to FFFF
    run_cmd("pre_wz", 2'b01, 3'd6, 3'd0, 16'h0000, 3, 2);
    run_cmd("decwrap", 2'b11, 3'd6, 3'd0, 16'h0000, 4, 2);
    check("decwrap.reg6", 16'(regs[6]), 16'h00FF);
    check("decwrap.reg7", 16'(regs[7]), 16'h00FF);

    // MOV8 with src == dst rewrites the same value
    run_cmd("movself", 2'b00, 3'd3, 3'd3, 16'h0000, 3, 1);
    check("movself.reg3", 16'(regs[3]), 16'h00EF);

    // Reset after the low-byte write of LD16 1234
    run_cmd("pre_rst", 2'b01, 3'd4, 3'd0, 16'hAABB, 3, 2);
    cmdValid = 1'b1; cmdOp = 2'b01; cmdDst = 3'd4; cmdImm = 16'h1234;
    step();
    cmdValid = 1'b0;
    check("rst.wrlo_we", 16'(bankWriteEnable), 16'd1);
    step();
    d0 = dcnt;
    reset = 1'b1;
    #1;
    check_idle_outputs("rst.async");
    step();
    step();
    @(negedge clk); reset = 1'b0;
    step();
    step();
    step();
    check("rst.no_done", 16'(dcnt - d0), 16'd0);
    check("rst.lo_written", 16'(regs[5]), 16'h0034);
    check("rst.hi_untouched", 16'(regs[4]), 16'h00AA);
    check_idle_outputs("rst.after");

    // Back-to-back with cmdValid held; fields change and valid pulses while busy
    cmdValid = 1'b1; cmdOp = 2'b01; cmdDst = 3'd0; cmdSrc = 3'd0; cmdImm = 16'h1122;
    step();
    cmdOp = 2'b00; cmdDst = 3'd5; cmdSrc = 3'd0; cmdImm = 16'hFFFF;
    step();
    cmdValid = 1'b0;
    step();
    cmdValid = 1'b1;
    check("b2b.done1", 16'(done), 16'd1);
    step();
    check("b2b.ready", 16'(cmdReady), 16'd1);
    check("b2b.busy_idle", 16'(busy), 16'd0);
    check("b2b.reg0", 16'(regs[0]), 16'h0011);
    check("b2b.reg1", 16'(regs[1]), 16'h0022);
    step();
    cmdValid = 1'b0;
    check("b2b.accept2", 16'(busy), 16'd1);
    check("b2b.read_reg", 16'(bankRegNum), 16'd0);
    step();
    check("b2b.wr_reg", 16'(bankRegNum), 16'd5);
    check("b2b.wr_data", 16'(bankDataIn), 16'h0011);
    step();
    check("b2b.done2", 16'(done), 16'd1);
    check("b2b.reg5", 16'(regs[5]), 16'h0011);
    step();
    check_idle_outputs("b2b.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
